// File: rtl/manh_weight_updater_if.sv
`default_nettype none
// ============================================================================
//  Module      : manh_weight_updater_if
//  Description : Weight / gradient memory bus used by the Manhattan-rule
//                weight updater. Master = updater, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface manh_weight_updater_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        grad_sign;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  modport master (
    output w_rd_en, w_addr, w_wr_en, w_wr_addr, w_wr_data,
    input  w_rd_data, grad_sign
  );

  modport slave (
    input  w_rd_en, w_addr, w_wr_en, w_wr_addr, w_wr_data,
    output w_rd_data, grad_sign
  );
endinterface
`default_nettype wire

// File: rtl/manh_weight_updater.sv
`default_nettype none
// ============================================================================
//  Module      : manh_weight_updater
//  Description : One Manhattan-rule update sweep over both layers per start
//                strobe: read old weight + gradient sign, step by +/-ETA,
//                write back. Three-stage pipeline (read, data, write).
//                Optional macro MANH_SAT_EN: saturate results to the signed
//                range instead of two's-complement wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module manh_weight_updater #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int L1_COUNT = 20,
  parameter int L2_COUNT = 10,
  parameter int ETA      = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              training_mode,
  input  wire logic              old_weight_rd,
  manh_weight_updater_if.master  mem,
  output logic                   busy,
  output logic                   first_manh_finished,
  output logic                   second_manh_finished
);

  localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(L1_COUNT + L2_COUNT - 1);
  localparam logic [ADDR_W-1:0] c_L1_LAST = ADDR_W'(L1_COUNT - 1);
  localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);
  localparam logic [DATA_W:0]   c_ETA_EXT = (DATA_W+1)'(ETA);
`ifdef MANH_SAT_EN
  localparam logic [DATA_W-1:0] c_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] c_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_drain;
  logic              r_v2;
  logic [ADDR_W-1:0] r_a2;
  logic [DATA_W:0]   w_old_ext;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;

  // Sweep control: issue one read per cycle, then two drain cycles so the
  // last two weights leave the pipeline before a new start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain     <= 1'b0;
      busy        <= 1'b0;
      mem.w_rd_en <= 1'b0;
      mem.w_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (old_weight_rd && training_mode) begin
            r_state     <= S_SWEEP;
            busy        <= 1'b1;
            mem.w_rd_en <= 1'b1;
            mem.w_addr  <= '0;
          end
        end
        S_SWEEP: begin
          if (mem.w_addr == c_LAST) begin
            r_state     <= S_DRAIN;
            r_drain     <= 1'b0;
            mem.w_rd_en <= 1'b0;
            mem.w_addr  <= '0;
          end else begin
            mem.w_addr  <= mem.w_addr + c_ONE;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          mem.w_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Track which address the returning memory data belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_a2 <= '0;
    end else begin
      r_v2 <= mem.w_rd_en;
      r_a2 <= mem.w_addr;
    end
  end

  // Manhattan step at one extra bit so the overflow is visible before reduction.
  always_comb begin
    w_old_ext = {mem.w_rd_data[DATA_W-1], mem.w_rd_data};
    case (mem.grad_sign)
      2'b01:   w_sum = w_old_ext - c_ETA_EXT;
      2'b11:   w_sum = w_old_ext + c_ETA_EXT;
      default: w_sum = w_old_ext;
    endcase
`ifdef MANH_SAT_EN
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_res = w_sum[DATA_W] ? c_MIN : c_MAX;
    end else begin
      w_res = w_sum[DATA_W-1:0];
    end
`else
    w_res = w_sum[DATA_W-1:0];
`endif
  end

  // Registered write-back port; data holds its last value between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.w_wr_en   <= 1'b0;
      mem.w_wr_addr <= '0;
      mem.w_wr_data <= '0;
    end else begin
      mem.w_wr_en   <= r_v2;
      mem.w_wr_addr <= r_a2;
      if (r_v2) begin
        mem.w_wr_data <= w_res;
      end
    end
  end

  // Layer-done pulses follow the cycle in which each layer's last weight is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_manh_finished  <= 1'b0;
      second_manh_finished <= 1'b0;
    end else begin
      first_manh_finished  <= mem.w_wr_en && (mem.w_wr_addr == c_L1_LAST);
      second_manh_finished <= mem.w_wr_en && (mem.w_wr_addr == c_LAST);
    end
  end

endmodule
`default_nettype wire
